// File: rtl/div_arbiter.sv
// Two-requester round-robin arbiter sharing one repeated-subtraction divider.
// Optional macro DIV_ZERO_CHECK_EN: a zero divisor ends the division with err set.
module div_arbiter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] A0,
  input  logic [WIDTH-1:0] B0,
  input  logic             req1,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] B1,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] rem,
  output logic             ack0,
  output logic             ack1,
  output logic             busy,
  output logic             err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state, state_nxt;
  logic [WIDTH-1:0] m, m_nxt;
  logic [WIDTH-1:0] n, n_nxt;
  logic [WIDTH-1:0] q, q_nxt;
  logic [WIDTH-1:0] count_nxt, rem_nxt;
  logic             ack0_nxt, ack1_nxt, busy_nxt;
  logic             gnt, gnt_nxt;
  logic             last, last_nxt;
  logic             pick;

`ifdef DIV_ZERO_CHECK_EN
  logic err_q, err_nxt;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // State and datapath registers; reset leaves requester 1 as last served
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= IDLE;
      m     <= '0;
      n     <= '0;
      q     <= '0;
      count <= '0;
      rem   <= '0;
      ack0  <= 1'b0;
      ack1  <= 1'b0;
      busy  <= 1'b0;
      gnt   <= 1'b0;
      last  <= 1'b1;
`ifdef DIV_ZERO_CHECK_EN
      err_q <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      m     <= m_nxt;
      n     <= n_nxt;
      q     <= q_nxt;
      count <= count_nxt;
      rem   <= rem_nxt;
      ack0  <= ack0_nxt;
      ack1  <= ack1_nxt;
      busy  <= busy_nxt;
      gnt   <= gnt_nxt;
      last  <= last_nxt;
`ifdef DIV_ZERO_CHECK_EN
      err_q <= err_nxt;
`endif
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt = state;
    m_nxt     = m;
    n_nxt     = n;
    q_nxt     = q;
    count_nxt = count;
    rem_nxt   = rem;
    ack0_nxt  = ack0;
    ack1_nxt  = ack1;
    busy_nxt  = busy;
    gnt_nxt   = gnt;
    last_nxt  = last;
`ifdef DIV_ZERO_CHECK_EN
    err_nxt   = err_q;
`endif
    // On a tie the requester not served last wins
    pick = (req0 && req1) ? ~last : req1;

    case (state)
      IDLE: begin
        if (req0 || req1) begin
          gnt_nxt   = pick;
          m_nxt     = pick ? A1 : A0;
          n_nxt     = pick ? B1 : B0;
          q_nxt     = '0;
          busy_nxt  = 1'b1;
          state_nxt = RUN;
`ifdef DIV_ZERO_CHECK_EN
          err_nxt   = 1'b0;
`endif
        end
      end
      RUN: begin
`ifdef DIV_ZERO_CHECK_EN
        if (n == '0) begin
          count_nxt = '1;
          rem_nxt   = m;
          err_nxt   = 1'b1;
          ack0_nxt  = ~gnt;
          ack1_nxt  = gnt;
          state_nxt = DONE;
        end else
`endif
        if (m >= n) begin
          m_nxt = m - n;
          q_nxt = q + WIDTH'(1);
        end else begin
          count_nxt = q;
          rem_nxt   = m;
          ack0_nxt  = ~gnt;
          ack1_nxt  = gnt;
          state_nxt = DONE;
        end
      end
      DONE: begin
        ack0_nxt  = 1'b0;
        ack1_nxt  = 1'b0;
        busy_nxt  = 1'b0;
        last_nxt  = gnt;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_div_arbiter.sv
// Self-checking bench for div_arbiter: directed cases plus randomized round-robin traffic
// checked against a quotient/remainder and fairness model.
module tb_div_arbiter;

  localparam int unsigned WIDTH = 16;

  logic             Clk = 1'b0;
  logic             Rst;
  logic             req0, req1;
  logic [WIDTH-1:0] A0, B0, A1, B1;
  logic [WIDTH-1:0] count, rem;
  logic             ack0, ack1, busy, err;

  int checks = 0;
  int errors = 0;
  bit last_served;

  div_arbiter #(.WIDTH(WIDTH)) dut (
    .Clk(Clk), .Rst(Rst),
    .req0(req0), .A0(A0), .B0(B0),
    .req1(req1), .A1(A1), .B1(B1),
    .count(count), .rem(rem),
    .ack0(ack0), .ack1(ack1), .busy(busy), .err(err)
  );

  always #5 Clk = ~Clk;

  task automatic do_reset();
    Rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    A0 = '0; B0 = '0; A1 = '0; B1 = '0;
    repeat (2) @(posedge Clk);
    @(negedge Clk) Rst = 1'b0;
    last_served = 1'b1;
  endtask

  // Expects a grant on the next rising edge; returns what the ack cycle looked like,
  // drops the served request, then steps one more edge back into IDLE.
  task automatic wait_ack(input int budget, output bit got, output bit who, output int lat,
                          output logic [WIDTH-1:0] c, output logic [WIDTH-1:0] r,
                          output logic e, output logic both, output logic bz);
    got = 1'b0; who = 1'b0; lat = 0; c = '0; r = '0; e = 1'b0; both = 1'b0; bz = 1'b0;
    @(posedge Clk);
    for (int i = 1; i <= budget; i++) begin
      @(posedge Clk); #1;
      if (ack0 || ack1) begin
        got = 1'b1; lat = i;
        break;
      end
    end
    if (got) begin
      who = ack1; c = count; r = rem; e = err; both = ack0 & ack1; bz = busy;
      if (ack0) req0 = 1'b0;
      if (ack1) req1 = 1'b0;
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({count, rem, ack0, ack1, busy, err} !== '0) begin
      errors++;
      $display("FAIL reset_state got count=%0d rem=%0d ack0=%b ack1=%b busy=%b err=%b want all zero",
               count, rem, ack0, ack1, busy, err);
    end
  endtask

  task automatic test_basic();
    bit got, who; int lat; logic [WIDTH-1:0] c, r; logic e, both, bz;
    do_reset();
    A0 = 16'd7; B0 = 16'd2; req0 = 1'b1;
    wait_ack(50, got, who, lat, c, r, e, both, bz);
    checks++;
    if (!got || who !== 1'b0 || both !== 1'b0) begin
      errors++; $display("FAIL basic_ack got=%b who=%b both=%b want got=1 who=0 both=0", got, who, both);
    end
    checks++;
    if (lat != 4) begin errors++; $display("FAIL basic_latency got %0d want 4", lat); end
    checks++;
    if (c !== 16'd3 || r !== 16'd1) begin
      errors++; $display("FAIL basic_result got %0d/%0d want 3/1", c, r);
    end
    checks++;
    if (bz !== 1'b1 || busy !== 1'b0 || e !== 1'b0) begin
      errors++; $display("FAIL basic_busy got busy_at_ack=%b busy_idle=%b err=%b want 1 0 0", bz, busy, e);
    end
    // No request: outputs must hold
    repeat (5) @(posedge Clk);
    #1;
    checks++;
    if (count !== 16'd3 || rem !== 16'd1 || busy !== 1'b0 || ack0 !== 1'b0 || ack1 !== 1'b0) begin
      errors++; $display("FAIL idle_hold got %0d/%0d busy=%b ack=%b%b want 3/1 0 00", count, rem, busy, ack1, ack0);
    end
  endtask

  task automatic test_tie();
    bit got, who; int lat; logic [WIDTH-1:0] c, r; logic e, both, bz;
    do_reset();
    A0 = 16'd9; B0 = 16'd3; A1 = 16'd10; B1 = 16'd4; req0 = 1'b1; req1 = 1'b1;
    wait_ack(50, got, who, lat, c, r, e, both, bz);
    checks++;
    if (!got || who !== 1'b0 || c !== 16'd3 || r !== 16'd0 || lat != 4) begin
      errors++; $display("FAIL tie_first got got=%b who=%b %0d/%0d lat=%0d want 0 3/0 lat=4", got, who, c, r, lat);
    end
    wait_ack(50, got, who, lat, c, r, e, both, bz);
    checks++;
    if (!got || who !== 1'b1 || c !== 16'd2 || r !== 16'd2 || lat != 3) begin
      errors++; $display("FAIL tie_second got got=%b who=%b %0d/%0d lat=%0d want 1 2/2 lat=3", got, who, c, r, lat);
    end
  endtask

  task automatic test_back_to_back();
    bit got, who; int lat; logic [WIDTH-1:0] c, r; logic e, both, bz;
    do_reset();
    A0 = 16'd20; B0 = 16'd6; A1 = 16'd15; B1 = 16'd7;
    for (int k = 0; k < 4; k++) begin
      req0 = 1'b1; req1 = 1'b1;
      wait_ack(50, got, who, lat, c, r, e, both, bz);
      checks++;
      if (!got || who !== 1'(k % 2) || both !== 1'b0) begin
        errors++; $display("FAIL b2b_order[%0d] got got=%b who=%b want who=%0d", k, got, who, k % 2);
      end
    end
  endtask

  task automatic test_small();
    bit got, who; int lat; logic [WIDTH-1:0] c, r; logic e, both, bz;
    do_reset();
    A0 = 16'd3; B0 = 16'd5; req0 = 1'b1;
    wait_ack(50, got, who, lat, c, r, e, both, bz);
    checks++;
    if (!got || who !== 1'b0 || lat != 1 || c !== 16'd0 || r !== 16'd3) begin
      errors++; $display("FAIL a_lt_b got got=%b who=%b lat=%0d %0d/%0d want 0 lat=1 0/3", got, who, lat, c, r);
    end
  endtask

  task automatic test_reset_mid();
    bit got, who; int lat; logic [WIDTH-1:0] c, r; logic e, both, bz; int acks;
    do_reset();
    A0 = 16'd7; B0 = 16'd2; req0 = 1'b1;
    wait_ack(50, got, who, lat, c, r, e, both, bz);
    A0 = 16'd100; B0 = 16'd1; req0 = 1'b1;
    @(posedge Clk); #1;
    A1 = 16'd8; B1 = 16'd3; req1 = 1'b1;
    repeat (10) @(posedge Clk);
    #2 Rst = 1'b1;
    #1;
    checks++;
    if ({count, rem, ack0, ack1, busy, err} !== '0) begin
      errors++; $display("FAIL reset_mid_outputs got %0d/%0d ack=%b%b busy=%b want 0/0 00 0", count, rem, ack1, ack0, busy);
    end
    acks = 0;
    repeat (3) begin @(posedge Clk); #1; if (ack0 || ack1) acks++; end
    @(negedge Clk) Rst = 1'b0;
    checks++;
    if (acks != 0) begin errors++; $display("FAIL reset_mid_noack got %0d acks want 0", acks); end
    last_served = 1'b1;
    wait_ack(300, got, who, lat, c, r, e, both, bz);
    checks++;
    if (!got || who !== 1'b0 || c !== 16'd100 || r !== 16'd0 || lat != 101) begin
      errors++; $display("FAIL reset_regrant got got=%b who=%b %0d/%0d lat=%0d want 0 100/0 lat=101", got, who, c, r, lat);
    end
    wait_ack(50, got, who, lat, c, r, e, both, bz);
    checks++;
    if (!got || who !== 1'b1 || c !== 16'd2 || r !== 16'd2) begin
      errors++; $display("FAIL reset_second got got=%b who=%b %0d/%0d want 1 2/2", got, who, c, r);
    end
  endtask

  task automatic test_div_zero();
    bit got, who; int lat; logic [WIDTH-1:0] c, r; logic e, both, bz;
    do_reset();
    A1 = 16'd5; B1 = 16'd0; req1 = 1'b1;
`ifdef DIV_ZERO_CHECK_EN
    wait_ack(50, got, who, lat, c, r, e, both, bz);
    checks++;
    if (!got || who !== 1'b1 || lat != 1 || c !== 16'hFFFF || r !== 16'd5 || e !== 1'b1) begin
      errors++; $display("FAIL div_zero got got=%b who=%b lat=%0d %h/%0d err=%b want 1 lat=1 ffff/5 err=1", got, who, lat, c, r, e);
    end
    A0 = 16'd7; B0 = 16'd2; req0 = 1'b1;
    wait_ack(50, got, who, lat, c, r, e, both, bz);
    checks++;
    if (!got || e !== 1'b0 || c !== 16'd3) begin
      errors++; $display("FAIL div_zero_clear got got=%b err=%b count=%0d want err=0 count=3", got, e, c);
    end
`else
    wait_ack(40, got, who, lat, c, r, e, both, bz);
    checks++;
    if (got || busy !== 1'b1 || err !== 1'b0) begin
      errors++; $display("FAIL div_zero_stall got ack=%b busy=%b err=%b want ack=0 busy=1 err=0", got, busy, err);
    end
    do_reset();
`endif
  endtask

  task automatic test_random();
    bit got, who, exp_who; int lat; logic [WIDTH-1:0] c, r; logic e, both, bz;
    bit pend [2];
    int a [2];
    int b [2];
    do_reset();
    pend[0] = 1'b0; pend[1] = 1'b0;
    for (int it = 0; it < 30; it++) begin
      for (int k = 0; k < 2; k++) begin
        if (!pend[k] && ($urandom_range(0, 1) == 1)) begin
          pend[k] = 1'b1; a[k] = $urandom_range(0, 3000); b[k] = $urandom_range(3, 300);
        end
      end
      if (!pend[0] && !pend[1]) begin
        pend[0] = 1'b1; a[0] = $urandom_range(0, 3000); b[0] = $urandom_range(3, 300);
      end
      A0 = WIDTH'(a[0]); B0 = WIDTH'(b[0]); req0 = pend[0];
      A1 = WIDTH'(a[1]); B1 = WIDTH'(b[1]); req1 = pend[1];
      exp_who = (pend[0] && pend[1]) ? !last_served : pend[1];
      wait_ack(1200, got, who, lat, c, r, e, both, bz);
      checks++;
      if (!got || who !== exp_who || c !== WIDTH'(a[exp_who] / b[exp_who]) ||
          r !== WIDTH'(a[exp_who] % b[exp_who]) || lat != a[exp_who] / b[exp_who] + 1) begin
        errors++;
        $display("FAIL random[%0d] got got=%b who=%b %0d/%0d lat=%0d want who=%b %0d/%0d lat=%0d",
                 it, got, who, c, r, lat, exp_who, a[exp_who] / b[exp_who], a[exp_who] % b[exp_who],
                 a[exp_who] / b[exp_who] + 1);
        do_reset();
        pend[0] = 1'b0; pend[1] = 1'b0;
      end else begin
        last_served = exp_who;
        pend[exp_who] = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tie();
    test_back_to_back();
    test_small();
    test_reset_mid();
    test_div_zero();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
